// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scanner with per-frame data latching,
// anti-ghosting guard interval, per-digit blink and decimal points.
module seg7_scan_driver #(
    parameter int DIGIT_TICKS  = 100_000,
    parameter int GUARD_TICKS  = 2_000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] seg_data,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int CW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] cnt;
    logic [1:0]    digit;
    logic [15:0]   shadow_data;
    logic [3:0]    shadow_dp;
    logic [3:0]    shadow_blink;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;

    logic          frame_start;
    logic          cnt_wrap;
    logic          frame_wrap;
    logic [15:0]   cur_data;
    logic [3:0]    cur_dp;
    logic [3:0]    nibble;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;

    assign frame_start = (cnt == '0) && (digit == 2'd0);
    assign cnt_wrap    = (cnt == CW'(DIGIT_TICKS - 1));
    assign frame_wrap  = (frame_cnt == FW'(BLINK_FRAMES - 1));

    // Look ahead to the data being latched so the cathodes show the new
    // frame's digit 0 for its whole slot, guard interval included.
    assign cur_data = frame_start ? seg_data : shadow_data;
    assign cur_dp   = frame_start ? dp_mask  : shadow_dp;

    always_comb begin
        nibble = 4'hF;
        unique case (digit)
            2'd0: nibble = cur_data[3:0];
            2'd1: nibble = cur_data[7:4];
            2'd2: nibble = cur_data[11:8];
            2'd3: nibble = cur_data[15:12];
        endcase
    end

    always_comb begin
        seg_next = 7'h7F;
        unique case (nibble)
            4'h0: seg_next = 7'h40;
            4'h1: seg_next = 7'h79;
            4'h2: seg_next = 7'h24;
            4'h3: seg_next = 7'h30;
            4'h4: seg_next = 7'h19;
            4'h5: seg_next = 7'h12;
            4'h6: seg_next = 7'h02;
            4'h7: seg_next = 7'h78;
            4'h8: seg_next = 7'h00;
            4'h9: seg_next = 7'h10;
            4'hA: seg_next = 7'h2B;
            4'hB: seg_next = 7'h3F;
            4'hC: seg_next = 7'h21;
            4'hD: seg_next = 7'h41;
            4'hE: seg_next = 7'h0C;
            4'hF: seg_next = 7'h7F;
        endcase
    end

    always_comb begin
        an_next = 4'hF;
        if (enable && (cnt >= CW'(GUARD_TICKS))
            && !(shadow_blink[digit] && !blink_phase))
            an_next = ~(4'b0001 << digit);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            digit <= 2'd0;
        end else if (cnt_wrap) begin
            cnt   <= '0;
            digit <= digit + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_data  <= 16'hFFFF;
            shadow_dp    <= 4'h0;
            shadow_blink <= 4'h0;
            frame_cnt    <= '0;
            blink_phase  <= 1'b1;
            frame_tick   <= 1'b0;
        end else begin
            frame_tick <= frame_start;
            if (frame_start) begin
                shadow_data  <= seg_data;
                shadow_dp    <= dp_mask;
                shadow_blink <= blink_mask;
                if (frame_wrap) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= 4'hF;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= ~cur_dp[digit];
        end
    end

endmodule
